// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: FSM states, opcodes, ALU_Op,
// datapath select codes and ALU_Control codes.
package rv_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALUCTL_W = 3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_e;

  localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  // Immediate format implied by the opcode; unknown opcodes default to I.
  function automatic logic [1:0] imm_src_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ALU_Op + func3/func7[5]/opcode[5] -> ALU_Control; shared with the single-cycle core.
module alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e              i_alu_op,
  input  logic [2:0]           i_func3,
  input  logic                 i_func7_5,
  input  logic                 i_op_5,
  output logic [ALUCTL_W-1:0]  o_alu_control
);

  // Subtract only for R-type (opcode[5]=1) with func7[5] set; ADDI ignores func7.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (i_func3)
          3'b000:  o_alu_control = (i_op_5 && i_func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multi-cycle RV32I core: steps each
// instruction through its states and drives the per-cycle datapath controls.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ready,
  input  logic                zero,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  output logic                mem_req,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [1:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                instr_done,
  output logic                illegal
);

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_illegal;
  alu_op_e              w_alu_op;
  logic                 w_mem_req, w_adr_src, w_mem_write, w_ir_write;
  logic                 w_pc_write, w_reg_write, w_instr_done;
  logic [1:0]           w_src_a, w_src_b, w_result_src;
  logic [ALUCTL_W-1:0]  w_alu_control;
  logic                 w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_alu_op     = ALUOP_ADD;
    w_mem_req    = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RD2;
    w_result_src = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALURES;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
        if (mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_R:         w_state_next = S_EXECUTER;
          OP_I:         w_state_next = S_EXECUTEI;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_JAL:       w_state_next = S_JAL;
          default: begin
            if (ILLEGAL_TRAP) begin
              w_state_next = S_TRAP;
            end else begin
              w_state_next = S_FETCH;
              w_instr_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a = SRCA_RD1;
        w_src_b = SRCB_IMM;
        if (opcode == OP_LW)      w_state_next = S_MEMREAD;
        else if (opcode == OP_SW) w_state_next = S_MEMWRITE;
        else                      w_state_next = S_FETCH;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req    = 1'b1;
        w_mem_write  = 1'b1;
        w_adr_src    = 1'b1;
        w_instr_done = mem_ready;
        if (mem_ready) w_state_next = S_FETCH;
      end
      S_EXECUTER: begin
        w_src_a      = SRCA_RD1;
        w_alu_op     = ALUOP_FUNC;
        w_state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_src_a      = SRCA_RD1;
        w_src_b      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNC;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BEQ: begin
        w_src_a      = SRCA_RD1;
        w_alu_op     = ALUOP_SUB;
        w_pc_write   = zero;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        w_src_a      = SRCA_OLDPC;
        w_src_b      = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_FETCH;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .i_alu_op      (w_alu_op),
    .i_func3       (func3),
    .i_func7_5     (func7[5]),
    .i_op_5        (opcode[5]),
    .o_alu_control (w_alu_control)
  );

  // Reset masks every enable and select so nothing is written while held.
  assign mem_req     = w_mem_req    & ~rst;
  assign adr_src     = w_adr_src    & ~rst;
  assign mem_write   = w_mem_write  & ~rst;
  assign ir_write    = w_ir_write   & ~rst;
  assign pc_write    = w_pc_write   & ~rst;
  assign reg_write   = w_reg_write  & ~rst;
  assign instr_done  = w_instr_done & ~rst;
  assign alu_src_a   = rst ? 2'b00 : w_src_a;
  assign alu_src_b   = rst ? 2'b00 : w_src_b;
  assign result_src  = rst ? 2'b00 : w_result_src;
  assign imm_src     = rst ? 2'b00 : imm_src_of(opcode);
  assign alu_control = rst ? 3'b000 : w_alu_control;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle scoreboard bench for multicycle_control_fsm, covering both the
// trapping and the NOP-retiring treatment of unknown opcodes.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst, mem_ready, zero;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  logic       t_mem_req, t_adr_src, t_mem_write, t_ir_write, t_pc_write, t_reg_write;
  logic [1:0] t_src_a, t_src_b, t_result_src, t_imm_src;
  logic [2:0] t_alu_control;
  logic       t_instr_done, t_illegal;
  logic       n_mem_req, n_adr_src, n_mem_write, n_ir_write, n_pc_write, n_reg_write;
  logic [1:0] n_src_a, n_src_b, n_result_src, n_imm_src;
  logic [2:0] n_alu_control;
  logic       n_instr_done, n_illegal;

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .zero(zero),
    .opcode(opcode), .func3(func3), .func7(func7),
    .mem_req(t_mem_req), .adr_src(t_adr_src), .mem_write(t_mem_write),
    .ir_write(t_ir_write), .pc_write(t_pc_write), .reg_write(t_reg_write),
    .alu_src_a(t_src_a), .alu_src_b(t_src_b), .result_src(t_result_src),
    .imm_src(t_imm_src), .alu_control(t_alu_control),
    .instr_done(t_instr_done), .illegal(t_illegal)
  );

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .zero(zero),
    .opcode(opcode), .func3(func3), .func7(func7),
    .mem_req(n_mem_req), .adr_src(n_adr_src), .mem_write(n_mem_write),
    .ir_write(n_ir_write), .pc_write(n_pc_write), .reg_write(n_reg_write),
    .alu_src_a(n_src_a), .alu_src_b(n_src_b), .result_src(n_result_src),
    .imm_src(n_imm_src), .alu_control(n_alu_control),
    .instr_done(n_instr_done), .illegal(n_illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] obs_t, obs_n;
  assign obs_t = {t_mem_req, t_adr_src, t_mem_write, t_ir_write, t_pc_write, t_reg_write,
                  t_src_a, t_src_b, t_result_src, t_imm_src, t_alu_control,
                  t_instr_done, t_illegal};
  assign obs_n = {n_mem_req, n_adr_src, n_mem_write, n_ir_write, n_pc_write, n_reg_write,
                  n_src_a, n_src_b, n_result_src, n_imm_src, n_alu_control,
                  n_instr_done, n_illegal};

  logic [18:0] q_t[$];
  logic [18:0] q_n[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  // Output vector order: mem_req adr_src mem_write ir_write pc_write reg_write
  // src_a src_b result_src imm_src alu_control instr_done illegal
  function automatic logic [18:0] ov(input logic mreq, adr, mw, irw, pcw, rw,
                                     input logic [1:0] sa, sb, rs, imm,
                                     input logic [2:0] ac, input logic dn, il);
    ov = {mreq, adr, mw, irw, pcw, rw, sa, sb, rs, imm, ac, dn, il};
  endfunction

  function automatic logic [18:0] fetch_v(input logic [1:0] imm, input logic mr);
    fetch_v = ov(1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 2'b10, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [18:0] dec_v(input logic [1:0] imm);
    dec_v = ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [18:0] memadr_v(input logic [1:0] imm);
    memadr_v = ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [18:0] aluwb_v(input logic [1:0] imm);
    aluwb_v = ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction

  // Drive one cycle's inputs, queue what each DUT must show, compare mid-cycle.
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [18:0] et, input logic [18:0] en);
    logic [18:0] e;
    mem_ready = mr;
    zero      = z;
    q_t.push_back(et);
    q_n.push_back(en);
    @(negedge clk);
    e = q_t.pop_front();
    check(tag, obs_t, e);
    e = q_n.pop_front();
    check({tag, "_nop"}, obs_n, e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input string tag, input logic mr, input logic z, input logic [18:0] e);
    cyc(tag, mr, z, e, e);
  endtask

  localparam logic [18:0] ZERO_V = 19'd0;
  localparam logic [18:0] TRAP_V = 19'd1;

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = 32'h00002083;
    @(posedge clk); #1;
    cyc2("reset", 1, 0, ZERO_V);
    rst = 1'b0;

    // LW, no wait states: 5 cycles
    cyc2("lw_fetch",   1, 0, fetch_v(2'b00, 1));
    cyc2("lw_decode",  1, 0, dec_v(2'b00));
    cyc2("lw_memadr",  1, 0, memadr_v(2'b00));
    cyc2("lw_memread", 1, 0, ov(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
    cyc2("lw_memwb",   1, 0, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1, 0));

    // SW with a fetch wait and three store wait cycles
    instr = 32'h00102023;
    cyc2("sw_fetch_wait", 0, 0, fetch_v(2'b01, 0));
    cyc2("sw_fetch",      1, 0, fetch_v(2'b01, 1));
    cyc2("sw_decode",     1, 0, dec_v(2'b01));
    cyc2("sw_memadr",     1, 0, memadr_v(2'b01));
    for (int i = 0; i < 3; i++)
      cyc2("sw_memwrite_wait", 0, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
    cyc2("sw_memwrite_done", 1, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));

    // Reset in the middle of a stalled store
    cyc2("rsw_fetch",   1, 0, fetch_v(2'b01, 1));
    cyc2("rsw_decode",  1, 0, dec_v(2'b01));
    cyc2("rsw_memadr",  1, 0, memadr_v(2'b01));
    cyc2("rsw_memwrite", 0, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
    rst = 1'b1;
    cyc2("rsw_in_reset", 1, 0, ZERO_V);
    rst = 1'b0;
    cyc2("rsw_post_fetch", 0, 0, fetch_v(2'b01, 0));

    // R-type SUB
    instr = 32'h402081B3;
    cyc2("sub_fetch",  1, 0, fetch_v(2'b00, 1));
    cyc2("sub_decode", 1, 0, dec_v(2'b00));
    cyc2("sub_exec",   1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
    cyc2("sub_aluwb",  1, 0, aluwb_v(2'b00));

    // R-type SLT
    instr = 32'h0020A1B3;
    cyc2("slt_fetch",  1, 0, fetch_v(2'b00, 1));
    cyc2("slt_decode", 1, 0, dec_v(2'b00));
    cyc2("slt_exec",   1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b101, 0, 0));
    cyc2("slt_aluwb",  1, 0, aluwb_v(2'b00));

    // ADDI with func7[5]=1 still adds
    instr = 32'h40008093;
    cyc2("addi_fetch",  1, 0, fetch_v(2'b00, 1));
    cyc2("addi_decode", 1, 0, dec_v(2'b00));
    cyc2("addi_exec",   1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0));
    cyc2("addi_aluwb",  1, 0, aluwb_v(2'b00));

    // BEQ taken then not taken
    instr = 32'h00208463;
    for (int z = 1; z >= 0; z--) begin
      cyc2("beq_fetch",  1, 1'(z), fetch_v(2'b10, 1));
      cyc2("beq_decode", 1, 1'(z), dec_v(2'b10));
      cyc2("beq_exec",   1, 1'(z),
           ov(0, 0, 0, 0, 1'(z), 0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001, 1, 0));
    end
    zero = 1'b0;

    // JAL
    instr = 32'h008000EF;
    cyc2("jal_fetch",  1, 0, fetch_v(2'b11, 1));
    cyc2("jal_decode", 1, 0, dec_v(2'b11));
    cyc2("jal_exec",   1, 0, ov(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000, 0, 0));
    cyc2("jal_aluwb",  1, 0, aluwb_v(2'b11));

    // Unknown opcode: trap instance sticks in TRAP, NOP instance retires it
    instr = 32'h0000007F;
    cyc2("ill_fetch", 1, 0, fetch_v(2'b00, 1));
    cyc("ill_decode", 0, 0, dec_v(2'b00),
        ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
    for (int i = 0; i < 3; i++)
      cyc("ill_after", 0, 0, TRAP_V, fetch_v(2'b00, 0));
    cyc("ill_hold_ready", 1, 0, TRAP_V, fetch_v(2'b00, 1));

    rst = 1'b1;
    cyc2("ill_reset", 1, 0, ZERO_V);
    rst = 1'b0;
    cyc2("ill_post_reset", 0, 0, fetch_v(2'b00, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer for the multi-cycle RV32I core variant, where one shared ALU and one unified instruction/data memory are reused across several cycles per instruction.
- Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle datapath selects and write enables.
- Adds a memory-ready handshake and an illegal-opcode trap.
- The ALU_Control encoding is identical to the single-cycle core.

Parameters:
- ILLEGAL_TRAP, default 1: 1 = an unknown opcode enters TRAP (sticky); 0 = an unknown opcode is retired as a NOP (DECODE -> FETCH).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_ready  in  1  memory completes the current access this cycle
- zero  in  1  ALU zero flag, valid in BEQ
- opcode  in  7  instruction register bits [6:0]
- func3  in  3  instruction register bits [14:12]
- func7  in  7  instruction register bits [31:25]
- mem_req  out  1  memory access request
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  store enable
- ir_write  out  1  instruction register / OldPC load
- pc_write  out  1  PC load
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J (decoded from opcode)
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky trap flag

Behaviour:
- Reset: state = FETCH; illegal = 0. While rst is high, all enables (mem_req, mem_write, ir_write, pc_write, reg_write, instr_done) are forced to 0 and every select is 00.
- Opcodes:
  - LW 0000011
  - SW 0100011
  - R 0110011
  - I-ALU 0010011
  - BEQ 1100011
  - JAL 1101111
- ALU_Op is internal:
  - 00 -> add
  - 01 -> sub
  - 10 -> decode from func3/func7[5]/opcode[5]; sub only when R-type and func7[5] = 1
- Per-state outputs; unlisted outputs are 0.
  - FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, ALU_Op=00, result_src=10; ir_write=pc_write=mem_ready.
  - DECODE: src_a=01, src_b=01, ALU_Op=00 (branch target into ALUOut).
  - MEMADR: src_a=10, src_b=01, ALU_Op=00.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1, instr_done=1.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; instr_done=mem_ready.
  - EXECUTER: src_a=10, src_b=00, ALU_Op=10.
  - EXECUTEI: src_a=10, src_b=01, ALU_Op=10.
  - ALUWB: result_src=00, reg_write=1, instr_done=1.
  - BEQ: src_a=10, src_b=00, ALU_Op=01, result_src=00, pc_write=zero, instr_done=1.
  - JAL: src_a=01, src_b=10, ALU_Op=00, result_src=00, pc_write=1.
  - TRAP: all enables 0; illegal=1.
- Transitions:
  - FETCH -> DECODE on mem_ready; otherwise hold.
  - DECODE: LW/SW -> MEMADR; R -> EXECUTER; I -> EXECUTEI; BEQ -> BEQ; JAL -> JAL; any other opcode -> TRAP (ILLEGAL_TRAP=1) or FETCH with instr_done=1 (ILLEGAL_TRAP=0).
  - MEMADR: LW -> MEMREAD; SW -> MEMWRITE.
  - MEMREAD -> MEMWB on mem_ready; otherwise hold.
  - MEMWRITE -> FETCH on mem_ready; otherwise hold with mem_write held high.
  - EXECUTER, EXECUTEI -> ALUWB.
  - JAL -> ALUWB (writes PC+4 to rd).
  - ALUWB, MEMWB, BEQ -> FETCH.
  - TRAP -> TRAP until rst.
- Latency with mem_ready always 1: LW 5 cycles, SW 4, R/I 4, BEQ 3, JAL 4. Each wait cycle adds 1.
- The opcode is sampled only from DECODE onward. The IR is stable after FETCH, so opcode is not re-registered.
- Outputs are combinational from state (plus mem_ready/zero as listed). Only the state and illegal are registered.
- Reset asserted mid-instruction: immediate return to FETCH; any write in progress is abandoned with no pulse after reset assertion.
- Unused state encodings -> FETCH.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - ALU_Op codes
  - alu_src_a/b, result_src and imm_src encodings
  - ALU_Control codes
- One sub-module: alu_op_decoder (combinational ALU_Op, func3, func7[5], opcode[5] -> alu_control), shared with the single-cycle core.
- The FSM state register and the next-state/output logic live in the top.

Test Plan:
- rst=1 mid-MEMWRITE, then released: next cycle is FETCH; mem_write=0 during reset; illegal=0.
- LW (0x00002083) with mem_ready=1: sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 in cycle 5; instr_done pulses once.
- SW with mem_ready low for 3 cycles in MEMWRITE: mem_write held for 4 cycles; instr_done only in the last; then FETCH.
- R-type SUB (func7=0100000, func3=000): alu_control=001 in EXECUTER. R-type SLT (func3=010): 101. ADDI with func7[5]=1: 000.
- BEQ with zero=1: pc_write=1 in state 3 with result_src=00. With zero=0: pc_write=0. Both return to FETCH.
- Opcode 1111111 with ILLEGAL_TRAP=1: TRAP; illegal=1 held indefinitely; no enables asserted. With ILLEGAL_TRAP=0: back to FETCH after 2 cycles, instr_done=1.
